// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants and FSM encoding for the shift-add multiplier controller.
// Both the RTL and the bench import this package.
package shift_add_mult_ctrl_pkg;

   localparam int MULT_N = 32;
   localparam int CNT_W  = $clog2(MULT_N) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// 32-bit ripple-carry adder used as the single shared datapath adder.
// Z = A + B, and Cout is the carry out of bit 31.
module adder_32_bit (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Cout,
   output logic [31:0] Z
);

   always_comb begin
      logic carry;
      carry = 1'b0;
      Z     = '0;
      for (int i = 0; i < 32; i++) begin
         Z[i]  = A[i] ^ B[i] ^ carry;
         carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
      end
      Cout = carry;
   end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add unsigned multiplier: one add-and-shift step per RUN cycle,
// N steps per product, with a one-cycle DONE pulse and a held product register.
module shift_add_mult_ctrl
   import shift_add_mult_ctrl_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output state_e         state_dbg
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N-1:0]       mcand_q, mcand_d;
   logic [N-1:0]       hi_q, hi_d;
   logic [N-1:0]       lo_q, lo_d;
   logic [2*N-1:0]     product_q, product_d;

   logic [N-1:0]       addend;
   logic [N-1:0]       add_sum;
   logic               add_cout;
   logic               accept;
   logic               last_step;

   assign accept    = (state_q == ST_IDLE) && start;
   assign last_step = (state_q == ST_RUN) && (cnt_q == LAST_STEP);
   assign addend    = lo_q[0] ? mcand_q : '0;

   adder_32_bit u_adder (
      .A    (hi_q),
      .B    (addend),
      .Cout (add_cout),
      .Z    (add_sum)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         product_q <= product_d;
      end
   end

   // Next-state logic: start is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)     state_d = ST_RUN;
         ST_RUN:  if (last_step) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Datapath next values; the carry-out becomes the new hi MSB after the shift.
   always_comb begin
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      product_d = product_q;
      if (accept) begin
         mcand_d = mcand;
         hi_d    = '0;
         lo_d    = mplier;
         cnt_d   = '0;
      end else if (state_q == ST_RUN) begin
         hi_d  = {add_cout, add_sum[N-1:1]};
         lo_d  = {add_sum[0], lo_q[N-1:1]};
         cnt_d = cnt_q + 1'b1;
         if (last_step) product_d = {add_cout, add_sum, lo_q[N-1:1]};
      end
   end

   // Moore outputs.
   always_comb begin
      busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
      done      = (state_q == ST_DONE);
      product   = product_q;
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl: hand-computed products, fixed latency,
// ignored starts, mid-run reset and back-to-back operation.
module tb_shift_add_mult_ctrl;
  import shift_add_mult_ctrl_pkg::*;

  localparam int N = MULT_N;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  state_e         state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] last_prod;

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mcand     (mcand),
    .mplier    (mplier),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // driver: one multiply, optionally poking start at RUN step 10 and in DONE
  task automatic mult_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input logic poke);
    int lat, busy_n, done_n, hold_bad;
    logic [2*N-1:0] want;
    lat = 0; busy_n = 0; done_n = 0; hold_bad = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mcand  = $urandom;
        mplier = $urandom;
      end
      start = poke && (c == 10 || c == N + 1);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        lat = c;
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check_val({tag, "/product"}, product, want);
          last_prod = want;
        end
      end else if (c <= N && product !== last_prod) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    check_val({tag, "/latency"}, lat, N + 1);
    check_val({tag, "/busy_cycles"}, busy_n, N + 1);
    check_val({tag, "/done_pulses"}, done_n, 1);
    check_val({tag, "/hold_in_run"}, hold_bad, 0);
  endtask

  initial begin
    int done_n, d1, d2;
    logic [2*N-1:0] want;
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    check_val("reset/busy", busy, 0);
    check_val("reset/done", done, 0);
    check_val("reset/product", product, 0);
    check_val("reset/state", state_dbg, ST_IDLE);
    rst = 1'b0;

    mult_op("3x5", 32'd3, 32'd5, 64'd15, 1'b0);
    mult_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    mult_op("0x1234", 32'd0, 32'h1234_5678, 64'd0, 1'b0);
    mult_op("1234x0", 32'h1234_5678, 32'd0, 64'd0, 1'b0);
    mult_op("poke", 32'h0000_1000, 32'd3, 64'h3000, 1'b1);

    // reset in the middle of RUN step 16 of 7x9
    @(negedge clk);
    mcand = 32'd7; mplier = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check_val("midrst/pre_state", state_dbg, ST_RUN);
    check_val("midrst/pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_val("midrst/busy", busy, 0);
    check_val("midrst/done", done, 0);
    check_val("midrst/product", product, 0);
    check_val("midrst/state", state_dbg, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    last_prod = '0;
    done_n = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check_val("midrst/no_done", done_n, 0);
    mult_op("7x9", 32'd7, 32'd9, 64'd63, 1'b0);

    // start held high: (2,3) then (4,5)
    exp_q.push_back(64'd6);
    exp_q.push_back(64'd20);
    done_n = 0; d1 = 0; d2 = 0;
    @(negedge clk);
    mcand = 32'd2; mplier = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2 * N + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mcand = 32'd4; mplier = 32'd5;
      end
      if (c == N + 3) begin
        start = 1'b0; mcand = $urandom; mplier = $urandom;
      end
      if (done) begin
        done_n++;
        if (done_n == 1) d1 = c;
        else d2 = c;
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check_val("b2b/product", product, want);
        end
      end
    end
    start = 1'b0;
    check_val("b2b/done_pulses", done_n, 2);
    check_val("b2b/first_latency", d1, N + 1);
    check_val("b2b/spacing", d2 - d1, N + 2);

    check_val("scoreboard/empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
